// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequence engine.
//   fib_state_e  : FSM state encoding (IDLE/INIT/ITER/DONE)
//   FIB_BASE_VAL : value of F(0) and F(1); the engine seeds both terms with it
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } fib_state_e;

  localparam int FIB_BASE_VAL = 1;

endpackage

// File: rtl/fib_step_add.sv
// One Fibonacci step: W-bit add returning the sum and the carry out.
// Kept separate so multi-channel engines can instantiate one per lane.
//   a, b  : in  W  operands (F(i-1), F(i))
//   sum   : out W  (a+b) mod 2^W
//   carry : out 1  carry out of the W-bit add
module fib_step_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fib_seq_engine.sv
// Multi-cycle Fibonacci engine, F(0)=F(1)=1, one adder, start/valid/ack handshake.
// Optional macro FIB_RAM_WR_EN streams every term F(2)..F(N) into RAM port A,
// one write per ITER cycle; when undefined the ram_* outputs are tied 0.
//   clk, reset             : clock, synchronous active-high reset
//   start, n_in, base_addr : request (sampled in IDLE only), index N, RAM base
//   busy                   : high in INIT and ITER
//   result_valid, result   : F(N) mod 2^DATA_W, held in DONE until result_ack
//   ovf                    : some term of the run overflowed DATA_W bits
//   result_ack             : consumer accepts result (DONE only)
//   ram_wren/addr/data     : term write port
module fib_seq_engine
  import fib_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 16,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  n_in,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  input  logic              result_ack,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data
);

  fib_state_e        state;
  logic [IDX_W-1:0]  n_q;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [DATA_W-1:0] a;     // F(idx-1)
  logic [DATA_W-1:0] b;     // F(idx)
  logic [DATA_W-1:0] s;
  logic              c;

  assign idx_nxt = idx + IDX_W'(1);

  fib_step_add #(.W(DATA_W)) u_step (
    .a     (a),
    .b     (b),
    .sum   (s),
    .carry (c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      ovf          <= 1'b0;
      n_q          <= '0;
      idx          <= '0;
      a            <= '0;
      b            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_q   <= n_in;
            busy  <= 1'b1;
            state <= INIT;
          end
        end
        INIT: begin
          a   <= DATA_W'(FIB_BASE_VAL);
          b   <= DATA_W'(FIB_BASE_VAL);
          idx <= IDX_W'(1);
          ovf <= 1'b0;
          if (n_q <= IDX_W'(1)) begin
            result       <= DATA_W'(FIB_BASE_VAL);
            busy         <= 1'b0;
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            state <= ITER;
          end
        end
        ITER: begin
          a   <= b;
          b   <= s;
          idx <= idx_nxt;
          ovf <= ovf | c;
          if (idx_nxt == n_q) begin
            result       <= s;
            busy         <= 1'b0;
            result_valid <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          // start in this cycle is deliberately dropped: a new run needs IDLE
          if (result_ack) begin
            result_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIB_RAM_WR_EN
  logic [ADDR_W-1:0] base_q;
  logic              wr_act;

  always_ff @(posedge clk) begin
    if (reset)                        base_q <= '0;
    else if (state == IDLE && start)  base_q <= base_addr;
  end

  // Gated by reset so an aborted run never lands a write on the reset edge.
  assign wr_act   = (state == ITER) && !reset;
  assign ram_wren = wr_act;
  assign ram_addr = wr_act ? base_q + ADDR_W'(idx) + ADDR_W'(1) : '0;
  assign ram_data = wr_act ? s : '0;
`else
  logic unused_base;
  assign unused_base = &{1'b0, base_addr};
  assign ram_wren    = 1'b0;
  assign ram_addr    = '0;
  assign ram_data    = '0;
`endif

endmodule

// File: tb/tb_fib_seq_engine.sv
// Scoreboard bench for fib_seq_engine: stimulus pushes expected results
// (and, with FIB_RAM_WR_EN, expected term writes); a monitor pops and compares.
module tb_fib_seq_engine;

  localparam int DATA_W = 16;
  localparam int IDX_W  = 16;
  localparam int ADDR_W = 13;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [IDX_W-1:0]  n_in = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              result_ack = 1'b0;
  logic              busy, result_valid, ovf, ram_wren;
  logic [DATA_W-1:0] result, ram_data;
  logic [ADDR_W-1:0] ram_addr;

  fib_seq_engine #(.DATA_W(DATA_W), .IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .n_in         (n_in),
    .base_addr    (base_addr),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .ovf          (ovf),
    .result_ack   (result_ack),
    .ram_wren     (ram_wren),
    .ram_addr     (ram_addr),
    .ram_data     (ram_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { longint res; longint ov; int kcyc; int lat; } exp_t;
  typedef struct { longint addr; longint data; } wr_t;
  exp_t exp_q[$];
  wr_t  wr_q[$];

  // Exact Fibonacci with F(0)=F(1)=1, in 64-bit arithmetic (N kept <= 40).
  function automatic longint fib(int n);
    longint x = 1, y = 1, t;
    for (int i = 2; i <= n; i++) begin
      t = x + y; x = y; y = t;
    end
    return y;
  endfunction

  task automatic chk(string nm, longint got, longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic fail(string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  // Monitor: result on rising result_valid, writes on every ram_wren.
  logic rv_d = 1'b0;
  exp_t mon_e;
  wr_t  mon_w;
  always @(negedge clk) begin
    if (mon_en) begin
      if (result_valid && !rv_d) begin
        if (exp_q.size() == 0) fail("unexpected_result");
        else begin
          mon_e = exp_q.pop_front();
          chk("result", longint'(result), mon_e.res);
          chk("ovf", longint'(ovf), mon_e.ov);
          chk("latency", longint'(cyc - mon_e.kcyc), longint'(mon_e.lat));
          chk("busy_in_done", longint'(busy), 0);
`ifndef FIB_RAM_WR_EN
          chk("ram_tied", longint'({ram_wren, ram_addr, ram_data}), 0);
`endif
        end
      end
      if (ram_wren) begin
`ifdef FIB_RAM_WR_EN
        if (wr_q.size() == 0) fail("unexpected_write");
        else begin
          mon_w = wr_q.pop_front();
          chk("ram_addr", longint'(ram_addr), mon_w.addr);
          chk("ram_data", longint'(ram_data), mon_w.data);
        end
`else
        chk("ram_wren_disabled", longint'(ram_wren), 0);
`endif
      end
    end
    rv_d <= result_valid;
  end

  task automatic run(int n, int base, int hold, bit noise, bit ack_start);
    exp_t e;
    wr_t  w;
    int   t;
    longint f;
    @(negedge clk);
    start = 1'b1; n_in = IDX_W'(n); base_addr = ADDR_W'(base);
    @(negedge clk);
    start = 1'b0; n_in = IDX_W'($urandom); base_addr = ADDR_W'($urandom);
    f      = fib(n);
    e.res  = f % 65536;
    e.ov   = (f > 65535) ? 1 : 0;
    e.kcyc = cyc;
    e.lat  = (n < 1) ? 1 : n;
    exp_q.push_back(e);
`ifdef FIB_RAM_WR_EN
    for (int i = 2; i <= n; i++) begin
      w.addr = (base + i) % 8192;
      w.data = fib(i) % 65536;
      wr_q.push_back(w);
    end
`endif
    chk("busy_init", longint'(busy), 1);
    t = 0;
    while (!result_valid && t < 200) begin
      if (noise && busy) start = 1'($urandom);
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    if (!result_valid) begin
      fail("timeout_result_valid");
      return;
    end
    for (int h = 0; h < hold; h++) begin
      chk("hold_result", longint'(result), e.res);
      chk("hold_valid", longint'(result_valid), 1);
      @(negedge clk);
    end
    result_ack = 1'b1; start = ack_start;
    @(negedge clk);
    result_ack = 1'b0; start = 1'b0;
    chk("ack_clears_valid", longint'(result_valid), 0);
    chk("ack_no_restart", longint'(busy), 0);
    chk("result_retained", longint'(result), e.res);
    @(negedge clk);
    chk("idle_busy", longint'(busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_valid", longint'(result_valid), 0);
    chk("rst_result", longint'(result), 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_ram", longint'({ram_wren, ram_addr, ram_data}), 0);
    reset = 1'b0;
    mon_en = 1'b1;

    run(0, 0, 0, 0, 0);
    run(1, 5, 1, 0, 0);
    run(10, 0, 3, 0, 0);
    run(24, 0, 1, 0, 0);
    run(23, 0, 1, 0, 0);
    run(5, 'h100, 1, 0, 0);
    run(30, 8190, 2, 1, 1);
    run(2, 7, 0, 1, 1);

    // Reset in the middle of a long run: nothing from it may surface.
    mon_en = 1'b0;
    @(negedge clk);
    start = 1'b1; n_in = 16'd20; base_addr = 13'h040;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_valid", longint'(result_valid), 0);
    chk("midrst_result", longint'(result), 0);
    chk("midrst_ovf", longint'(ovf), 0);
    chk("midrst_ram", longint'({ram_wren, ram_addr, ram_data}), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_still_idle", longint'(busy), 0);
    mon_en = 1'b1;
    run(5, 0, 1, 0, 0);

    for (int k = 0; k < 20; k++)
      run(int'($urandom_range(0, 40)), int'($urandom_range(0, 8191)),
          int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));

    repeat (3) @(negedge clk);
    chk("results_drained", longint'(exp_q.size()), 0);
    chk("writes_drained", longint'(wr_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
